// File: rtl/big_ram_arbiter_if.sv
// big_ram_arbiter_if: requester and RAM-port signal bundle for big_ram_arbiter.
//   slave  : arbiter side. Takes requests and ram_dout; drives acks, rdata, busy, RAM command.
//   master : environment side. Requesters plus the bigRam array.
`timescale 1ns/1ps
interface big_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              ram_en;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_dout,
        output ack0, ack1, rdata, busy, ram_en, ram_wr, ram_addr, ram_din
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  ack0, ack1, rdata, busy, ram_en, ram_wr, ram_addr, ram_din
    );
endinterface

// File: rtl/big_ram_arbiter.sv
// big_ram_arbiter: round-robin arbiter and sequencer for the single-port 256x32 bigRam.
// Ports:
//   Clk   - rising-edge clock shared with bigRam
//   Reset - synchronous active-high reset
//   bus   - big_ram_arbiter_if.slave: two request ports (req/wr/addr/wdata -> ack),
//           shared rdata, busy, and the RAM command port (ram_en/ram_wr/ram_addr/ram_din, ram_dout)
// All outputs are registered.
`timescale 1ns/1ps
module big_ram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    big_ram_arbiter_if.slave     bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic              sel_q,      sel_d;
    logic              last_q,     last_d;
    logic              ram_en_q,   ram_en_d;
    logic              ram_wr_q,   ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q,  ram_din_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              ack0_q,     ack0_d;
    logic              ack1_q,     ack1_d;
    logic              busy_q,     busy_d;
    logic              gnt;
    logic              do_gnt;

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            ram_en_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            ram_en_q   <= ram_en_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rdata_q    <= rdata_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        ram_en_d   = 1'b0;
        ram_wr_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rdata_d    = rdata_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        gnt        = 1'b0;
        do_gnt     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the port not served last wins
                if (bus.req0 && bus.req1) begin
                    do_gnt = 1'b1;
                    gnt    = ~last_q;
                end else if (bus.req0) begin
                    do_gnt = 1'b1;
                    gnt    = 1'b0;
                end else if (bus.req1) begin
                    do_gnt = 1'b1;
                    gnt    = 1'b1;
                end
                if (do_gnt) begin
                    sel_d      = gnt;
                    ram_en_d   = 1'b1;
                    ram_wr_d   = gnt ? bus.wr1    : bus.wr0;
                    ram_addr_d = gnt ? bus.addr1  : bus.addr0;
                    ram_din_d  = gnt ? bus.wdata1 : bus.wdata0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // RAM samples the command at the end of this cycle; address holds
                ram_din_d = '0;
                if (ram_wr_q) begin
                    ack0_d  = ~sel_q;
                    ack1_d  = sel_q;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rdata_d = bus.ram_dout;
                ack0_d  = ~sel_q;
                ack1_d  = sel_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                last_d  = sel_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.ram_en   = ram_en_q;
    assign bus.ram_wr   = ram_wr_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.rdata    = rdata_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_big_ram_arbiter.sv
// tb_big_ram_arbiter: directed bench for big_ram_arbiter with a bigRam model and an
// expected-ack scoreboard (port, access, address, data, ack cycle).
`timescale 1ns/1ps
module tb_big_ram_arbiter;

    typedef struct {
        bit          port;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   left [2];
    bit [31:0] mem    [256];
    bit [31:0] shadow [256];
    entry_t sb [$];

    big_ram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    big_ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // bigRam model: synchronous write, registered read
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_din;
            else            bus.ram_dout      <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input bit w, input logic [7:0] a, input logic [31:0] d, input int n);
        if (p) begin
            bus.req1 = 1'b1; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
        left[p] = n;
    endtask

    // Queue one expected completion, in grant order, with its ack cycle
    task automatic post(input bit p, input bit w, input logic [7:0] a, input logic [31:0] d, input int c);
        entry_t e;
        e.port = p; e.wr = w; e.addr = a; e.cyc = c;
        if (w) begin
            shadow[a] = d;
            e.data    = d;
        end else begin
            e.data = shadow[a];
        end
        sb.push_back(e);
    endtask

    // Run until every queued completion is seen; returns at the following IDLE cycle
    task automatic run(input int budget);
        entry_t e;
        int cyc = 0;
        int en_cnt = 0;
        int n_exp = sb.size();
        bit prev_ack = 1'b0;
        while (sb.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (prev_ack) chk("idle_busy", 32'(bus.busy), 32'd0);
            prev_ack = 1'b0;
            if (bus.ram_en) begin
                en_cnt++;
                chk("ram_addr", 32'(bus.ram_addr), 32'(sb[0].addr));
                chk("ram_wr", 32'(bus.ram_wr), 32'(sb[0].wr));
                if (sb[0].wr) chk("ram_din", bus.ram_din, sb[0].data);
            end else begin
                chk("ram_wr_idle", 32'(bus.ram_wr), 32'd0);
            end
            if (bus.ack0 || bus.ack1) begin
                e = sb.pop_front();
                chk("ack_port", 32'({bus.ack1, bus.ack0}), e.port ? 32'd2 : 32'd1);
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("ack_busy", 32'(bus.busy), 32'd1);
                if (!e.wr) chk("rdata", bus.rdata, e.data);
                prev_ack = 1'b1;
                left[e.port]--;
                if (left[e.port] == 0) begin
                    if (e.port) bus.req1 = 1'b0;
                    else        bus.req0 = 1'b0;
                end
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("ram_en_count", 32'(en_cnt), 32'(n_exp));
        @(negedge clk);
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        left[0] = 0; left[1] = 0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
        chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_ram_din", bus.ram_din, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        reset = 1'b0;

        // Single write on port 0, then read-back on port 1
        drive(1'b0, 1'b1, 8'h29, 32'h729FB2B2, 1);
        post(1'b0, 1'b1, 8'h29, 32'h729FB2B2, 2);
        run(20);
        drive(1'b1, 1'b0, 8'h29, 32'h0, 1);
        post(1'b1, 1'b0, 8'h29, 32'h0, 3);
        run(20);

        // Contention: simultaneous writes, port 0 wins the first tie
        drive(1'b0, 1'b1, 8'h6F, 32'h650444F1, 1);
        drive(1'b1, 1'b1, 8'hAA, 32'h0A3A275A, 1);
        post(1'b0, 1'b1, 8'h6F, 32'h650444F1, 2);
        post(1'b1, 1'b1, 8'hAA, 32'h0A3A275A, 5);
        run(30);

        // Both ports held requesting reads: grants alternate 0,1,0,1
        drive(1'b0, 1'b0, 8'h6F, 32'h0, 2);
        drive(1'b1, 1'b0, 8'hAA, 32'h0, 2);
        post(1'b0, 1'b0, 8'h6F, 32'h0, 3);
        post(1'b1, 1'b0, 8'hAA, 32'h0, 7);
        post(1'b0, 1'b0, 8'h6F, 32'h0, 11);
        post(1'b1, 1'b0, 8'hAA, 32'h0, 15);
        run(40);

        // Top address does not alias address 0
        drive(1'b0, 1'b1, 8'h00, 32'h13572468, 1);
        post(1'b0, 1'b1, 8'h00, 32'h13572468, 2);
        run(20);
        drive(1'b1, 1'b1, 8'hFF, 32'h47FF082B, 1);
        post(1'b1, 1'b1, 8'hFF, 32'h47FF082B, 2);
        run(20);
        drive(1'b0, 1'b0, 8'hFF, 32'h0, 1);
        post(1'b0, 1'b0, 8'hFF, 32'h0, 3);
        run(20);
        drive(1'b1, 1'b0, 8'h00, 32'h0, 1);
        post(1'b1, 1'b0, 8'h00, 32'h0, 3);
        run(20);

        // Reset during WAIT of a read, then the held request is reissued
        drive(1'b1, 1'b0, 8'h29, 32'h0, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
        chk("mid_rst_rdata", bus.rdata, 32'd0);
        chk("mid_rst_ram_en", 32'(bus.ram_en), 32'd0);
        post(1'b1, 1'b0, 8'h29, 32'h0, 3);
        run(20);

        // Request held one cycle past ack gets a second access
        drive(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 2);
        post(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 2);
        post(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 5);
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/big_ram_arbiter.md
# big_ram_arbiter

Two-port arbiter and sequencer for the 256 x 32 `bigRam` array. It accepts independent read/write requests from two requesters, grants them round-robin, and drives the single RAM port (`en`, `WR`, `Address`, `Din`) with correctly sequenced single-cycle accesses. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the RAM and the datapath/loader logic that previously drove `bigRam` directly.

## Interface
- `ADDR_W`, default 8: RAM address width; 256 words.
- `DATA_W`, default 32: RAM word width.

- `Clk`  in  1  rising-edge clock, shared with `bigRam`.
- `Reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  access request from requester 0 / 1. Held high until the matching ack.
- `wr0`, `wr1`  in  1  1 = write, 0 = read. Stable while req is high.
- `addr0`, `addr1`  in  ADDR_W  word address. Stable while req is high.
- `wdata0`, `wdata1`  in  DATA_W  write data. Stable while req is high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  read data, shared by both requesters. Valid in the ack cycle of a read.
- `busy`  out  1  high whenever the state is not IDLE.
- `ram_en`  out  1  to `bigRam.en`.
- `ram_wr`  out  1  to `bigRam.WR`.
- `ram_addr`  out  ADDR_W  to `bigRam.Address`.
- `ram_din`  out  DATA_W  to `bigRam.Din`.
- `ram_dout`  in  DATA_W  from `bigRam.Dout`. Valid the cycle after an edge that sampled `ram_en`=1 with `ram_wr`=0.

## Operation
- **States:** IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one reqN is high, grant it.
  - If both are high, grant the port that was not served last. The `last` pointer resets to 1, so port 0 wins the first tie.
  - On a grant, register `ram_addr`, `ram_din` and `ram_wr` from the granted port's inputs, set `ram_en`=1, record `sel`, and go to ISSUE.
- **ISSUE:** the RAM samples the command at the end of this cycle.
  - Clear `ram_en`, `ram_wr` and `ram_din`. `ram_addr` holds.
  - Write: go to ACK.
  - Read: go to WAIT.
- **WAIT** (reads only): register `ram_dout` into `rdata`, then go to ACK.
- **ACK**
  - Assert `ack[sel]`=1 for this cycle only.
  - Set `last`=`sel`.
  - Ignore all requests in this cycle, then go to IDLE.
- **Requester obligations**
  - Drop reqN at the edge ending its ack cycle.
  - A req still high in the following IDLE cycle is a new request and gets a repeat access.
- **Data flow:** write data passes through unmodified. `rdata` holds its last value until the next read completes.
- **Write ack:** `rdata` is not updated on writes.
- **Address range:** the full 0x00–0xFF range is legal; there is no wrap or range check.
- **Reset** (synchronous, any state)
  - Next state is IDLE.
  - `ram_en`=0, `ram_wr`=0, `ram_addr`=0, `ram_din`=0, `rdata`=0, `ack0`=`ack1`=0, `busy`=0, `last`=1.
  - If reset is asserted during ISSUE, the RAM may still commit that write at the same edge. The requester sees no ack and must reissue.
- **Outputs:** all are registered. None are driven combinationally from the inputs.

## Timing
- Request first sampled high in IDLE at cycle T:
  - Write: ISSUE in T+1, RAM write at the end of T+1, `ack` high in T+2. Latency 2.
  - Read: ISSUE in T+1, WAIT in T+2 (`ram_dout` valid), `ack` and `rdata` valid in T+3. Latency 3.
- **Throughput:** after ACK, IDLE takes one cycle before the next grant.
  - Back-to-back writes: one per 3 cycles.
  - Back-to-back reads: one per 4 cycles.
- **`busy`:** high from T+1 through the ack cycle inclusive.
- **Fairness under contention:** both ports continuously requesting are served strictly alternately. Neither waits more than one full access.
- **`ram_en` width:** exactly one cycle per access. `ram_wr` is high only in ISSUE of a write.

## Test plan
- **Single write, port 0.** Reset for 2 cycles, then `req0`=1, `wr0`=1, `addr0`=0x29, `wdata0`=0x729FB2B2. Expect `ram_en`=`ram_wr`=1 with `ram_addr`=0x29 in exactly one cycle, and `ack0` 2 cycles after the req is sampled. `ack1` stays 0.
- **Read-back, port 1.** After the previous write, `req1`=1, `wr1`=0, `addr1`=0x29. Expect `ack1` 3 cycles after the req is sampled, with `rdata`=0x729FB2B2.
- **Contention.** Both ports request writes at once: port 0 to 0x6F (0x650444F1) and port 1 to 0xAA (0x0A3A275A).
  - Port 0 is acked first and port 1 next.
  - With both held continuously requesting, grants alternate 0,1,0,1.
  - Reading back 0x6F and 0xAA returns the written data.
- **Top address.** Write 0x47FF082B to 0xFF, then read 0xFF. Expect 0x47FF082B and no effect on address 0x00.
- **Reset mid-read.** Assert `Reset` in the WAIT cycle of a read.
  - Next cycle: IDLE, `busy`=0, no ack, `rdata`=0.
  - The reissued read completes normally.
- **Held request.** Keep `req0` high for one extra cycle past `ack0`. Expect a second identical access with a new `ack0` pulse, and `busy`=0 in the intervening IDLE cycle.
